ks_voice_alloc: RTL and testbench

- Polyphonic voice allocator and sequencer for an array of NUM_VOICES Karplus-Strong string voices.
- Accepts note requests from the host or step sequencer over a valid/ready handshake and assigns each note to a string voice.
- Per voice, drives the pluck, period and drum/string-select inputs and tracks note duration.
- Steals a voice when all voices are busy.

---
 rtl/ks_pkg.sv | 17 +
 rtl/ks_voice_fsm.sv | 88 ++++++++
 rtl/ks_voice_alloc.sv | 101 ++++++++++
 tb/tb_ks_voice_alloc.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared definitions for the Karplus-Strong voice, string and mixer blocks.
package ks_pkg;

   typedef enum logic [1:0] {StIdle, StPluck, StGap, StRing} voice_state_e;

   localparam int unsigned GAP_CYCLES = 2;

   function automatic int unsigned clamp_period(input int unsigned period,
                                                input int unsigned max_len);
      int unsigned result;
      result = period;
      if (period < 2) result = 2;
      else if (period > max_len) result = max_len;
      return result;
   endfunction

endpackage

// File: rtl/ks_voice_fsm.sv
// One string voice: pluck/gap/ring sequencing, note-length countdown and latched config.
module ks_voice_fsm
   import ks_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned MAX_LENGTH   = 12,
   parameter int unsigned LEN_WIDTH    = 8,
   parameter int unsigned PLUCK_CYCLES = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_n,
   input  logic                  hold,
   input  logic                  all_off,
   input  logic                  tick,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_period,
   input  logic                  load_drum,
   input  logic [LEN_WIDTH-1:0]  load_len,
   output voice_state_e          state,
   output logic [LEN_WIDTH-1:0]  remain,
   output logic                  pluck,
   output logic [DATA_WIDTH-1:0] period,
   output logic                  drum
);

   // PLUCK_CYCLES >= GAP_CYCLES, so one counter sized for the pluck phase serves both.
   localparam int unsigned CNT_W = $clog2(PLUCK_CYCLES);
   localparam logic [CNT_W-1:0] LAST_PLUCK = CNT_W'(PLUCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] LAST_GAP   = CNT_W'(GAP_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state  <= StIdle;
         cnt    <= '0;
         remain <= '0;
         pluck  <= 1'b0;
         period <= DATA_WIDTH'(MAX_LENGTH);
         drum   <= 1'b0;
      end else if (all_off) begin
         state  <= StIdle;
         cnt    <= '0;
         remain <= '0;
         pluck  <= 1'b0;
      end else if (load) begin
         period <= load_period;
         drum   <= load_drum;
         remain <= load_len;
         cnt    <= '0;
         // A ringing voice is stolen via a low gap so the string sees a fresh pluck edge.
         if (state == StRing) begin
            state <= StGap;
            pluck <= 1'b0;
         end else begin
            state <= StPluck;
            pluck <= 1'b1;
         end
      end else if (!hold) begin
         unique case (state)
            StIdle: ;
            StPluck: begin
               if (cnt == LAST_PLUCK) begin
                  state <= StRing;
                  cnt   <= '0;
                  pluck <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            StGap: begin
               if (cnt == LAST_GAP) begin
                  state <= StPluck;
                  cnt   <= '0;
                  pluck <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            StRing: begin
               if (remain == '0) state <= StIdle;
               else if (tick) remain <= remain - 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/ks_voice_alloc.sv
// Polyphonic note allocator: picks a free (or stealable) voice per accepted note request.
module ks_voice_alloc
   import ks_pkg::*;
#(
   parameter int unsigned NUM_VOICES   = 4,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned MAX_LENGTH   = 12,
   parameter int unsigned LEN_WIDTH    = 8,
   parameter int unsigned PLUCK_CYCLES = 4,
   parameter int unsigned STEAL_EN     = 1
) (
   input  logic                             clk_i,
   input  logic                             rst_n,
   input  logic                             tick_i,
   input  logic                             hold_i,
   input  logic                             all_off_i,
   input  logic                             note_valid_i,
   output logic                             note_ready_o,
   input  logic [DATA_WIDTH-1:0]            note_period_i,
   input  logic                             note_drum_i,
   input  logic [LEN_WIDTH-1:0]             note_len_i,
   output logic [NUM_VOICES-1:0]            pluck_o,
   output logic [NUM_VOICES*DATA_WIDTH-1:0] period_o,
   output logic [NUM_VOICES-1:0]            drum_string_no,
   output logic [NUM_VOICES-1:0]            freeze_o,
   output logic [NUM_VOICES-1:0]            voice_busy_o,
   output logic                             steal_o
);

   localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   voice_state_e           state  [NUM_VOICES];
   logic [LEN_WIDTH-1:0]   remain [NUM_VOICES];
   logic                   any_idle;
   logic                   any_ring;
   logic [IDX_W-1:0]       idle_idx;
   logic [IDX_W-1:0]       ring_idx;
   logic [IDX_W-1:0]       target;
   logic [LEN_WIDTH-1:0]   best_len;
   logic                   accept;
   logic                   steal;
   logic [DATA_WIDTH-1:0]  clamped;

   // Lowest idle voice wins; otherwise the ringing voice closest to its end, lowest index on ties.
   always_comb begin
      any_idle = 1'b0;
      any_ring = 1'b0;
      idle_idx = '0;
      ring_idx = '0;
      best_len = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (state[v] == StIdle && !any_idle) begin
            any_idle = 1'b1;
            idle_idx = IDX_W'(v);
         end
         if (state[v] == StRing && (!any_ring || remain[v] < best_len)) begin
            any_ring = 1'b1;
            best_len = remain[v];
            ring_idx = IDX_W'(v);
         end
      end
      target = any_idle ? idle_idx : ring_idx;
   end

   assign note_ready_o = !hold_i && !all_off_i && (any_idle || ((STEAL_EN != 0) && any_ring));
   assign accept       = note_valid_i && note_ready_o;
   assign clamped      = DATA_WIDTH'(clamp_period(32'(note_period_i), MAX_LENGTH));
   assign freeze_o     = {NUM_VOICES{hold_i}};
   assign steal_o      = steal;

   always_ff @(posedge clk_i) begin
      if (!rst_n) steal <= 1'b0;
      else        steal <= accept && !any_idle;
   end

   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
      ks_voice_fsm #(
         .DATA_WIDTH   (DATA_WIDTH),
         .MAX_LENGTH   (MAX_LENGTH),
         .LEN_WIDTH    (LEN_WIDTH),
         .PLUCK_CYCLES (PLUCK_CYCLES)
      ) u_fsm (
         .clk_i       (clk_i),
         .rst_n       (rst_n),
         .hold        (hold_i),
         .all_off     (all_off_i),
         .tick        (tick_i),
         .load        (accept && (target == IDX_W'(v))),
         .load_period (clamped),
         .load_drum   (note_drum_i),
         .load_len    (note_len_i),
         .state       (state[v]),
         .remain      (remain[v]),
         .pluck       (pluck_o[v]),
         .period      (period_o[v*DATA_WIDTH +: DATA_WIDTH]),
         .drum        (drum_string_no[v])
      );
      assign voice_busy_o[v] = (state[v] != StIdle);
   end

endmodule

// File: tb/tb_ks_voice_alloc.sv
// Random plus directed bench: one stealing and one stalling allocator against a behavioural model.
module tb_ks_voice_alloc;

   logic clk = 1'b0;
   logic rst_n, tick, hold, all_off, valid, drum;
   logic [7:0] period, len;

   logic       ready_w [2];
   logic       steal_w [2];
   logic [3:0] pluck_w [2];
   logic [3:0] drum_w  [2];
   logic [3:0] frz_w   [2];
   logic [3:0] busy_w  [2];
   logic [31:0] per_w  [2];

   int checks = 0;
   int failures = 0;

   // Model: per voice, cycles of gap left, pluck cycles left, ringing flag and ticks left.
   int m_gap [2][4];
   int m_pl  [2][4];
   int m_len [2][4];
   int m_per [2][4];
   bit m_ring[2][4];
   bit m_drm [2][4];
   bit m_steal[2];
   bit mvalid = 1'b0;

   always #5 clk = ~clk;

   ks_voice_alloc #(.NUM_VOICES(4), .DATA_WIDTH(8), .MAX_LENGTH(12), .LEN_WIDTH(8),
                    .PLUCK_CYCLES(4), .STEAL_EN(1)) u_steal (
      .clk_i(clk), .rst_n(rst_n), .tick_i(tick), .hold_i(hold), .all_off_i(all_off),
      .note_valid_i(valid), .note_ready_o(ready_w[0]), .note_period_i(period),
      .note_drum_i(drum), .note_len_i(len), .pluck_o(pluck_w[0]), .period_o(per_w[0]),
      .drum_string_no(drum_w[0]), .freeze_o(frz_w[0]), .voice_busy_o(busy_w[0]),
      .steal_o(steal_w[0]));

   ks_voice_alloc #(.NUM_VOICES(4), .DATA_WIDTH(8), .MAX_LENGTH(12), .LEN_WIDTH(8),
                    .PLUCK_CYCLES(4), .STEAL_EN(0)) u_stall (
      .clk_i(clk), .rst_n(rst_n), .tick_i(tick), .hold_i(hold), .all_off_i(all_off),
      .note_valid_i(valid), .note_ready_o(ready_w[1]), .note_period_i(period),
      .note_drum_i(drum), .note_len_i(len), .pluck_o(pluck_w[1]), .period_o(per_w[1]),
      .drum_string_no(drum_w[1]), .freeze_o(frz_w[1]), .voice_busy_o(busy_w[1]),
      .steal_o(steal_w[1]));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_busy(input int i, input int v);
      return m_gap[i][v] > 0 || m_pl[i][v] > 0 || m_ring[i][v];
   endfunction

   function automatic bit m_ready(input int i);
      bit free = 1'b0;
      bit ring = 1'b0;
      for (int v = 0; v < 4; v++) begin
         if (!m_busy(i, v)) free = 1'b1;
         if (m_ring[i][v]) ring = 1'b1;
      end
      return !hold && !all_off && (free || (i == 0 && ring));
   endfunction

   task automatic model_step();
      int tgt;
      int best;
      bit stl;
      for (int i = 0; i < 2; i++) begin
         m_steal[i] = 1'b0;
         if (!rst_n) begin
            for (int v = 0; v < 4; v++) begin
               m_gap[i][v] = 0; m_pl[i][v] = 0; m_ring[i][v] = 0; m_len[i][v] = 0;
               m_per[i][v] = 12; m_drm[i][v] = 0;
            end
         end else if (all_off) begin
            for (int v = 0; v < 4; v++) begin
               m_gap[i][v] = 0; m_pl[i][v] = 0; m_ring[i][v] = 0;
            end
         end else begin
            tgt = -1;
            stl = 1'b0;
            if (valid && m_ready(i)) begin
               for (int v = 0; v < 4; v++)
                  if (tgt < 0 && !m_busy(i, v)) tgt = v;
               if (tgt < 0) begin
                  stl = 1'b1;
                  best = 1 << 30;
                  for (int v = 0; v < 4; v++)
                     if (m_ring[i][v] && m_len[i][v] < best) begin
                        best = m_len[i][v];
                        tgt = v;
                     end
               end
            end
            for (int v = 0; v < 4; v++) begin
               if (v == tgt || hold) continue;
               if (m_gap[i][v] > 0) m_gap[i][v]--;
               else if (m_pl[i][v] > 0) begin
                  m_pl[i][v]--;
                  if (m_pl[i][v] == 0) m_ring[i][v] = 1'b1;
               end else if (m_ring[i][v]) begin
                  if (m_len[i][v] == 0) m_ring[i][v] = 1'b0;
                  else if (tick) m_len[i][v]--;
               end
            end
            if (tgt >= 0) begin
               m_gap[i][tgt]  = stl ? 2 : 0;
               m_pl[i][tgt]   = 4;
               m_ring[i][tgt] = 1'b0;
               m_len[i][tgt]  = int'(len);
               m_per[i][tgt]  = (period < 2) ? 2 : ((period > 12) ? 12 : int'(period));
               m_drm[i][tgt]  = drum;
               m_steal[i]     = stl;
            end
         end
      end
      if (!rst_n) mvalid = 1'b1;
   endtask

   task automatic compare(input int i);
      logic [3:0]  ep, eb, ed;
      logic [31:0] eper;
      for (int v = 0; v < 4; v++) begin
         ep[v] = (m_gap[i][v] == 0) && (m_pl[i][v] > 0);
         eb[v] = m_busy(i, v);
         ed[v] = m_drm[i][v];
         eper[v*8 +: 8] = 8'(m_per[i][v]);
      end
      chk($sformatf("u%0d.pluck", i), 64'(pluck_w[i]), 64'(ep));
      chk($sformatf("u%0d.busy", i), 64'(busy_w[i]), 64'(eb));
      chk($sformatf("u%0d.period", i), 64'(per_w[i]), 64'(eper));
      chk($sformatf("u%0d.drum", i), 64'(drum_w[i]), 64'(ed));
      chk($sformatf("u%0d.steal", i), 64'(steal_w[i]), 64'(m_steal[i]));
      chk($sformatf("u%0d.ready", i), 64'(ready_w[i]), 64'(m_ready(i)));
      chk($sformatf("u%0d.freeze", i), 64'(frz_w[i]), 64'({4{hold}}));
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (mvalid) for (int i = 0; i < 2; i++) compare(i);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      valid = 0; tick = 0; hold = 0; all_off = 0;
   endtask

   task automatic quiesce();
      idle_in();
      all_off = 1;
      step();
      all_off = 0;
   endtask

   task automatic note(input int p, input int l, input bit d);
      valid = 1; period = 8'(p); len = 8'(l); drum = d;
   endtask

   initial begin
      int cnt;
      int cp[3];
      cp[0] = 0; cp[1] = 1; cp[2] = 200;
      rst_n = 0; idle_in(); period = 0; len = 0; drum = 0;
      repeat (3) step();
      rst_n = 1;
      #1;
      chk("rst.pluck", 64'(pluck_w[0]), 64'h0);
      chk("rst.busy", 64'(busy_w[0]), 64'h0);
      chk("rst.period", 64'(per_w[0]), 64'h0C0C0C0C);
      chk("rst.drum", 64'(drum_w[0]), 64'h0);
      chk("rst.steal", 64'(steal_w[0]), 64'h0);
      chk("rst.ready", 64'(ready_w[0]), 64'h1);

      // Single note: period 8, len 3, ticks every 10 clks.
      note(8, 3, 0);
      step();
      valid = 0;
      for (int k = 1; k <= 5; k++) begin
         chk($sformatf("n1.pluck_k%0d", k), 64'(pluck_w[0][0]), 64'(k <= 4));
         step();
      end
      chk("n1.period", 64'(per_w[0][7:0]), 64'd8);
      for (int i = 0; i < 30; i++) begin
         tick = (i % 10 == 9);
         step();
      end
      chk("n1.busy_after_3rd_tick", 64'(busy_w[0][0]), 64'h1);
      tick = 0;
      step();
      chk("n1.busy_clear", 64'(busy_w[0][0]), 64'h0);

      // Back-to-back notes fill voices in order.
      for (int n = 0; n < 4; n++) begin
         note(3 + n, 20, 0);
         #1;
         chk($sformatf("b2b.ready%0d", n), 64'(ready_w[0]), 64'h1);
         step();
         chk($sformatf("b2b.busy%0d", n), 64'(busy_w[0]), 64'((1 << (n + 1)) - 1));
      end
      #1;
      chk("b2b.stall_ready", 64'(ready_w[1]), 64'h0);
      step();
      quiesce();

      // Steal: remaining 5,2,2,7 -> voice 1 is the victim.
      note(4, 5, 0); step();
      note(5, 2, 0); step();
      note(6, 2, 0); step();
      note(7, 7, 0); step();
      valid = 0;
      repeat (5) step();
      chk("steal.all_ring_busy", 64'(busy_w[0]), 64'hF);
      chk("steal.all_ring_pluck", 64'(pluck_w[0]), 64'h0);
      note(9, 4, 1);
      #1;
      chk("steal.ready", 64'(ready_w[0]), 64'h1);
      chk("steal.stall_ready", 64'(ready_w[1]), 64'h0);
      step();
      valid = 0;
      chk("steal.period1", 64'(per_w[0][15:8]), 64'd9);
      for (int k = 1; k <= 7; k++) begin
         chk($sformatf("steal.pulse_k%0d", k), 64'(steal_w[0]), 64'(k == 1));
         chk($sformatf("steal.pluck_k%0d", k), 64'(pluck_w[0]), 64'((k >= 3 && k <= 6) ? 2 : 0));
         step();
      end
      quiesce();

      // Period clamp.
      for (int k = 0; k < 3; k++) begin
         note(cp[k], 0, k == 2);
         step();
      end
      valid = 0;
      chk("clamp.p0", 64'(per_w[0][7:0]), 64'd2);
      chk("clamp.p1", 64'(per_w[0][15:8]), 64'd2);
      chk("clamp.p200", 64'(per_w[0][23:16]), 64'd12);
      chk("clamp.drum", 64'(drum_w[0]), 64'h4);
      repeat (10) step();

      // Hold mid-pluck, then hold during ring with ticks.
      quiesce();
      note(5, 2, 0);
      step();
      valid = 0;
      cnt = pluck_w[0][0] ? 1 : 0;
      step();
      hold = 1; tick = 1;
      #1;
      chk("hold.ready", 64'(ready_w[0]), 64'h0);
      for (int j = 0; j < 6; j++) begin
         step();
         chk($sformatf("hold.pluck_j%0d", j), 64'(pluck_w[0][0]), 64'h1);
      end
      hold = 0; tick = 0;
      for (int j = 0; j < 10; j++) begin
         if (pluck_w[0][0]) cnt++;
         step();
      end
      chk("hold.pluck_cycles", 64'(cnt), 64'd4);
      hold = 1; tick = 1;
      repeat (5) step();
      hold = 0; tick = 0;
      repeat (3) step();
      chk("hold.ticks_ignored", 64'(busy_w[0][0]), 64'h1);

      // all_off beats a simultaneous request.
      quiesce();
      note(5, 5, 0); step(); step();
      all_off = 1;
      #1;
      chk("off.ready", 64'(ready_w[0]), 64'h0);
      step();
      chk("off.busy", 64'(busy_w[0]), 64'h0);
      chk("off.pluck", 64'(pluck_w[0]), 64'h0);
      all_off = 0;
      note(6, 5, 0);
      step();
      valid = 0;
      chk("off.next_voice0", 64'(busy_w[0]), 64'h1);
      chk("off.next_period", 64'(per_w[0][7:0]), 64'd6);

      // Reset mid-note.
      step();
      rst_n = 0;
      step();
      rst_n = 1;
      chk("rst2.busy", 64'(busy_w[0]), 64'h0);
      chk("rst2.pluck", 64'(pluck_w[0]), 64'h0);
      chk("rst2.period", 64'(per_w[0]), 64'h0C0C0C0C);

      for (int c = 0; c < 3000; c++) begin
         valid   = 1'($urandom_range(0, 1));
         tick    = ($urandom_range(0, 4) == 0);
         hold    = ($urandom_range(0, 19) == 0);
         all_off = ($urandom_range(0, 49) == 0);
         rst_n   = ($urandom_range(0, 499) != 0);
         period  = 8'($urandom_range(0, 255));
         len     = 8'($urandom_range(0, 6));
         drum    = 1'($urandom_range(0, 1));
         step();
      end
      idle_in();
      rst_n = 1;
      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
